// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the MEM port arbiter: requester indices, the
// number of requesters and the arbiter state encoding.
// Requester 0 is the UART data collector, 1 the systolic/scan engine and
// 2 the UART data sender.
package mem_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_COLLECT  = 2'd0;
  localparam logic [1:0] REQ_SYSTOLIC = 2'd1;
  localparam logic [1:0] REQ_SEND     = 2'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// rr_pick3
// Combinational three-way round-robin picker. The search starts at the
// requester after 'pointer' and wraps around, so the requester named by
// 'pointer' itself has the lowest priority.
// Ports:
//   req     [2:0]  request bits
//   pointer [1:0]  index of the most recent winner (2 restarts at 0)
//   winner  [1:0]  chosen requester, meaningful only when valid = 1
//   valid          at least one request is present
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] pointer,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  // Build the search order from the pointer, then take the first hit.
  // Any pointer value other than 0 or 1 behaves like 2, so the scan
  // starts at requester 0.
  always_comb begin
    first  = REQ_COLLECT;
    second = REQ_SYSTOLIC;
    third  = REQ_SEND;
    case (pointer)
      REQ_COLLECT: begin
        first  = REQ_SYSTOLIC;
        second = REQ_SEND;
        third  = REQ_COLLECT;
      end
      REQ_SYSTOLIC: begin
        first  = REQ_SEND;
        second = REQ_COLLECT;
        third  = REQ_SYSTOLIC;
      end
      default: ;
    endcase

    valid  = |req;
    winner = first;
    if (req[first])
      winner = first;
    else if (req[second])
      winner = second;
    else if (req[third])
      winner = third;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single MEM instance between the UART collector (0), the
// systolic/scan engine (1) and the UART sender (2). Arbitration is
// round-robin with an optional per-requester burst lock that is bounded
// by MAX_HOLD consecutive cycles. MEM reads are combinational, so rdata
// is valid in the same cycle the grant is high.
// Optional feature: define MEM_ARB_STATS_EN to build the saturating
// contention counter on coll_cnt; otherwise coll_cnt is tied to zero.
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   req, lock, we     per-requester request, burst lock, write enable
//   addr, wdata       packed per-requester address / write data
//   gnt               registered one-hot grant
//   rdata             read data broadcast to all requesters
//   mem_we, mem_wr_addr, mem_rd_addr, mem_wdata, mem_rdata  MEM side
//   busy              any grant active
//   oob_err           sticky out-of-range access flag
//   coll_cnt          contention counter (MEM_ARB_STATS_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int NUM_DATA = 2500,
  parameter int MAX_HOLD = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            lock,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  oob_err,
  output logic [15:0]           coll_cnt
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  // One extra bit so NUM_DATA = 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_DATA);

  arb_state_t        state;
  logic [1:0]        pointer;
  logic [HOLD_W-1:0] hold_cnt;

  logic              granted;
  logic              cur_req;
  logic              cur_lock;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              in_range;
  logic              stay;
  logic [1:0]        winner;
  logic              pick_valid;

  // While owning, the pointer doubles as the owner index.
  assign granted = (state == ARB_OWN);

  // Select the owner's request signals; everything reads as zero when idle.
  always_comb begin
    cur_req   = 1'b0;
    cur_lock  = 1'b0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    if (granted) begin
      case (pointer)
        REQ_COLLECT: begin
          cur_req   = req[0];
          cur_lock  = lock[0];
          cur_we    = we[0];
          cur_addr  = addr[0*ADDR_W +: ADDR_W];
          cur_wdata = wdata[0*DATA_W +: DATA_W];
        end
        REQ_SYSTOLIC: begin
          cur_req   = req[1];
          cur_lock  = lock[1];
          cur_we    = we[1];
          cur_addr  = addr[1*ADDR_W +: ADDR_W];
          cur_wdata = wdata[1*DATA_W +: DATA_W];
        end
        REQ_SEND: begin
          cur_req   = req[2];
          cur_lock  = lock[2];
          cur_we    = we[2];
          cur_addr  = addr[2*ADDR_W +: ADDR_W];
          cur_wdata = wdata[2*DATA_W +: DATA_W];
        end
        default: ;
      endcase
    end
  end

  assign in_range    = ({1'b0, cur_addr} < ADDR_LIMIT);
  assign mem_wr_addr = cur_addr;
  assign mem_rd_addr = cur_addr;
  assign mem_wdata   = cur_wdata;
  // A grant that outlives its request must not write.
  assign mem_we      = granted & cur_req & cur_we & in_range;
  assign rdata       = (granted && in_range) ? mem_rdata : '0;
  assign busy        = |gnt;

  // A locked owner keeps the port until the hold budget runs out.
  assign stay = granted & cur_req & cur_lock & (hold_cnt < HOLD_LAST);

  rr_pick3 u_pick (
    .req     (req),
    .pointer (pointer),
    .winner  (winner),
    .valid   (pick_valid)
  );

  // Grant FSM. Hold expiry falls into the normal scan, which re-grants
  // the same owner if nobody else is asking and rotates otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      pointer  <= REQ_SEND;
      hold_cnt <= '0;
      gnt      <= '0;
      oob_err  <= 1'b0;
    end else begin
      if (stay) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else if (pick_valid) begin
        state    <= ARB_OWN;
        pointer  <= winner;
        hold_cnt <= '0;
        gnt      <= 3'b001 << winner;
      end else begin
        state    <= ARB_IDLE;
        hold_cnt <= '0;
        gnt      <= '0;
      end
      if (granted && cur_req && !in_range)
        oob_err <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] coll_q;
  logic        contention;

  assign contention = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  // Counts edges with two or more simultaneous requests, saturating.
  always_ff @(posedge clk) begin
    if (!rst)
      coll_q <= '0;
    else if (contention && coll_q != 16'hFFFF)
      coll_q <= coll_q + 16'd1;
  end

  assign coll_cnt = coll_q;
`else
  assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (built with MAX_HOLD = 4).
// A vector table covers reset, round-robin rotation, plain writes and the
// burst lock limit; hand-written sequences cover write-then-read, grant
// outliving its request, out-of-range handling and the contention counter.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int NUM_DATA = 2500;
  localparam int MAX_HOLD = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [2:0]          lock;
  logic [2:0]          we;
  logic [ADDR_W-1:0]   a0, a1, a2;
  logic [DATA_W-1:0]   wd0, wd1, wd2;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [DATA_W-1:0]   rdata;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wr_addr;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic                oob_err;
  logic [15:0]         coll_cnt;

  int num_checks = 0;
  int num_errors = 0;

  assign addr  = {a2, a1, a0};
  assign wdata = {wd2, wd1, wd0};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .rdata       (rdata),
    .mem_we      (mem_we),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .oob_err     (oob_err),
    .coll_cnt    (coll_cnt)
  );

  // Stand-in for MEM: full 2**ADDR_W array so a leaked out-of-range write
  // would be visible. Location NUM_DATA holds a marker so an unsuppressed
  // out-of-range read shows up as nonzero rdata.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << ADDR_W); i++)
        mem[i] <= '0;
      mem[NUM_DATA] <= 8'h5A;
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_wr_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_rd_addr];

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] we;
    logic [2:0] exp_gnt;
    logic       exp_we;
  } vec_t;

  vec_t vecs [24];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst  = v.rst;
    req  = v.req;
    lock = v.lock;
    we   = v.we;
    step();
  endtask

  initial begin
    rst = 1'b0; req = 3'b111; lock = '0; we = '0;
    a0 = 14'd10; a1 = 14'd20; a2 = 14'd30;
    wd0 = 8'h11; wd1 = 8'h22; wd2 = 8'h33;

    //            rst   req     lock    we      gnt     mem_we
    vecs[0]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b001, 1'b0};
    vecs[3]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b010, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b100, 1'b0};
    vecs[5]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b001, 1'b0};
    vecs[6]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b010, 1'b0};
    vecs[7]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b100, 1'b0};
    vecs[8]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[9]  = '{1'b1, 3'b100, 3'b000, 3'b100, 3'b100, 1'b1};
    vecs[10] = '{1'b1, 3'b100, 3'b000, 3'b100, 3'b100, 1'b1};
    vecs[11] = '{1'b1, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0};
    vecs[12] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[13] = '{1'b1, 3'b111, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[14] = '{1'b1, 3'b111, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[15] = '{1'b1, 3'b111, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[16] = '{1'b1, 3'b111, 3'b010, 3'b000, 3'b100, 1'b0};
    vecs[17] = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b001, 1'b0};
    vecs[18] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[19] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[20] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[21] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[22] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};
    vecs[23] = '{1'b1, 3'b010, 3'b010, 3'b000, 3'b010, 1'b0};

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      checkOutput($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(|vecs[i].exp_gnt));
      checkOutput($sformatf("vec%0d oob_err", i), 32'(oob_err), 32'd0);
    end

    // Write by collector, then read back by sender.
    req = 3'b000; lock = '0; we = '0;
    step();
    a0 = 14'd100; wd0 = 8'hA5; req = 3'b001; we = 3'b001;
    step();
    checkOutput("wr gnt", 32'(gnt), 32'h1);
    checkOutput("wr mem_we", 32'(mem_we), 32'h1);
    checkOutput("wr mem_wr_addr", 32'(mem_wr_addr), 32'd100);
    checkOutput("wr mem_wdata", 32'(mem_wdata), 32'hA5);
    step();
    a2 = 14'd100; req = 3'b100; we = 3'b000;
    #1;
    checkOutput("drop gnt still high", 32'(gnt), 32'h1);
    checkOutput("drop mem_we", 32'(mem_we), 32'h0);
    step();
    checkOutput("rd gnt", 32'(gnt), 32'h4);
    checkOutput("rd mem_rd_addr", 32'(mem_rd_addr), 32'd100);
    checkOutput("rd rdata", 32'(rdata), 32'hA5);
    checkOutput("rd MEM[100]", 32'(mem[100]), 32'hA5);

    // Out-of-range write by the systolic engine, then the last legal address.
    req = 3'b000;
    step();
    a1 = 14'd2500; wd1 = 8'h3C; req = 3'b010; we = 3'b010;
    step();
    checkOutput("oob gnt", 32'(gnt), 32'h2);
    checkOutput("oob mem_we", 32'(mem_we), 32'h0);
    checkOutput("oob rdata", 32'(rdata), 32'h0);
    checkOutput("oob flag not yet", 32'(oob_err), 32'h0);
    step();
    checkOutput("oob flag set", 32'(oob_err), 32'h1);
    checkOutput("oob MEM[2500]", 32'(mem[2500]), 32'h5A);
    a1 = 14'd2499;
    #1;
    checkOutput("edge mem_we", 32'(mem_we), 32'h1);
    step();
    checkOutput("edge MEM[2499]", 32'(mem[2499]), 32'h3C);
    req = 3'b000; we = 3'b000;
    step();
    step();
    checkOutput("oob sticky", 32'(oob_err), 32'h1);
    rst = 1'b0;
    step();
    checkOutput("oob cleared", 32'(oob_err), 32'h0);
    checkOutput("reset gnt", 32'(gnt), 32'h0);

    // Contention counter: 10 edges of 011, then 5 edges of 001.
    rst = 1'b1; req = 3'b011;
    for (int i = 0; i < 10; i++)
      step();
    req = 3'b001;
    for (int i = 0; i < 5; i++)
      step();
`ifdef MEM_ARB_STATS_EN
    checkOutput("coll_cnt", 32'(coll_cnt), 32'd10);
`else
    checkOutput("coll_cnt", 32'(coll_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single MEM instance between three requesters: 0 = UART data collector (writes), 1 = systolic/scan engine (reads and writes), 2 = UART data sender (reads).
- Sits between those engines and MEM, replacing ad-hoc muxing of write_select, read_select, write_data and wr_enable.
- Uses round-robin arbitration with an optional burst lock, bounded by a hold limit.
- MEM read is combinational (no delay), so read data is valid in the same cycle the grant is high.

Parameters:
- ADDR_W, 14, address width (matches MEM select width).
- DATA_W, 8, data width.
- NUM_DATA, 2500, valid address range is 0..NUM_DATA-1.
- MAX_HOLD, 64, maximum consecutive cycles a locked owner may keep the grant.

Ports:
- clk  input  1  system clock (9.6 MHz domain).
- rst  input  1  reset, synchronous, active-low.
- req  input  3  per-requester access request.
- lock  input  3  per-requester burst lock; keep grant while req stays high.
- we  input  3  per-requester write enable (1 = write, 0 = read).
- addr  input  3*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  input  3*DATA_W  packed write data; same packing scheme.
- gnt  output  3  one-hot grant, registered.
- rdata  output  DATA_W  read data, broadcast to all requesters; valid only for the granted requester.
- mem_we  output  1  to MEM wr_enable.
- mem_wr_addr  output  ADDR_W  to MEM write_select.
- mem_rd_addr  output  ADDR_W  to MEM read_select.
- mem_wdata  output  DATA_W  to MEM write_data.
- mem_rdata  input  DATA_W  from MEM read_data.
- busy  output  1  OR of gnt.
- oob_err  output  1  sticky out-of-range access flag.
- coll_cnt  output  16  contention counter; see Optional Feature.

Behaviour:
- Reset (rst low at a clk edge):
  - gnt = 0, rr pointer = 2 (so requester 0 wins first), hold_cnt = 0, oob_err = 0, coll_cnt = 0.
  - mem_we = 0 in the same cycle, because gnt is 0.
  - Reset mid-burst aborts the burst. No write occurs in any cycle where gnt = 0.
- State: IDLE (gnt = 0) and OWN(i) (gnt[i] = 1). Owner index and hold_cnt are registered.
- Arbitration, evaluated at every clk edge from the current inputs:
  - In OWN(i), if req[i] & lock[i] & (hold_cnt < MAX_HOLD-1): stay in OWN(i), hold_cnt++.
  - Otherwise, scan requesters circularly starting at pointer+1. The first with req = 1 wins: go to OWN(winner), pointer = winner, hold_cnt = 0.
  - If no requester has req = 1: go to IDLE.
  - Hold expiry with no other requester pending: the same owner is re-granted and hold_cnt = 0.
  - Hold expiry with others pending: forced rotation to the next requester.
- Latency: req rising at edge N gives gnt high after edge N+1 at the earliest.
  - A sole requester with req held high gets the grant every cycle (one access per cycle), locked or not.
- Access, combinational, in any cycle where gnt[i] = 1:
  - mem_wr_addr = mem_rd_addr = addr[i].
  - mem_wdata = wdata[i].
  - mem_we = req[i] & we[i] & in_range.
  - rdata = in_range ? mem_rdata : 0.
  - When gnt = 0: MEM addresses = 0, wdata = 0, mem_we = 0, rdata = 0.
- Grant still high after the requester drops req: that cycle performs no write. gnt falls at the next edge.
- in_range is addr[i] < NUM_DATA. An out-of-range access while granted (read or write) sets oob_err = 1 at the next edge. The write is suppressed; oob_err stays set until reset.
- Boundary addresses: NUM_DATA-1 is a legal access; NUM_DATA is flagged.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: coll_cnt increments by 1 at every edge where two or more req bits are high. It saturates at 0xFFFF and clears on reset.
- Undefined: coll_cnt is tied to 0 and the counter logic is not built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - requester index constants REQ_COLLECT = 0, REQ_SYSTOLIC = 1, REQ_SEND = 2;
  - NUM_REQ = 3;
  - a state enum {ARB_IDLE, ARB_OWN}.
- One sub-module: rr_pick3, a combinational round-robin picker. Inputs: req[2:0], pointer[1:0]. Outputs: winner[1:0] and valid.
- Hold counter, oob logic and muxing stay in the top module.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with all req = 1 -> gnt = 0, mem_we = 0, oob_err = 0. After release, the first grant is gnt = 3'b001.
- Round-robin: req = 3'b111, lock = 0, held for 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100.
- Lock limit: MAX_HOLD = 4, requester 1 locked, req = 3'b111 -> gnt = 010 for exactly 4 cycles, then 100.
- Write/read: requester 0 writes 0xA5 to addr 100, then requester 2 reads addr 100 -> MEM[100] = 0xA5, and rdata = 0xA5 during requester 2's grant cycle.
- Out-of-range: requester 1 writes 0x3C to addr 2500 -> mem_we stays 0, MEM unchanged, oob_err = 1 from the next cycle until reset. A write to addr 2499 succeeds.
- Stats (MEM_ARB_STATS_EN defined): req = 3'b011 for 10 cycles, then 3'b001 for 5 cycles -> coll_cnt = 10.
